// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: FSM states and interval-timer register map shared by the scheduler
package timer_sched_pkg;
   typedef enum logic [1:0] {INIT, IDLE, CLEAR, TICK} sched_state_t;
   localparam logic [2:0] TMR_ADDR_STATUS = 3'd0;
   localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
   localparam logic [15:0] TMR_CTRL_RUN = 16'h0007;
endpackage

// File: rtl/timer_sched_channel.sv
// timer_sched_channel: one software timer channel with reload, oneshot and sticky pending flag
module timer_sched_channel #(
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic reset,
   input logic tick,
   input logic load,
   input logic [CNT_W-1:0] period,
   input logic oneshot,
   input logic stop,
   input logic ack,
   output logic expire,
   output logic pending,
   output logic active
);
   logic [CNT_W-1:0] per, cnt;
   logic os;
   assign expire = tick & active & (cnt == CNT_W'(1)) & ~load;
   always_ff @(posedge clk) begin
      if (reset) begin
         per <= '0;
         cnt <= '0;
         os <= 1'b0;
         active <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (load) begin
            per <= period;
            cnt <= period;
            os <= oneshot;
            active <= |period;
         end else begin
            if (tick && active) begin
               if (cnt == CNT_W'(1)) begin
                  if (os) active <= 1'b0;
                  else cnt <= per;
               end else cnt <= cnt - CNT_W'(1);
            end
            if (stop) active <= 1'b0;
         end
         pending <= expire | (pending & ~ack);
      end
   end
endmodule

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler: drives the interval timer and fans its ticks out to software channels; TMR_WATCHDOG_EN adds an irq watchdog
module timer_tick_scheduler
   import timer_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W = 16
`ifdef TMR_WATCHDOG_EN
   , parameter int WD_LIMIT = 65536
`endif
) (
   input logic clk,
   input logic reset,
   output logic [2:0] tmr_address,
   output logic tmr_chipselect,
   output logic tmr_write_n,
   output logic [15:0] tmr_writedata,
   input logic tmr_irq,
   input logic [NUM_CH-1:0] ch_load,
   input logic [NUM_CH*CNT_W-1:0] ch_period,
   input logic [NUM_CH-1:0] ch_oneshot,
   input logic [NUM_CH-1:0] ch_stop,
   input logic [NUM_CH-1:0] ch_ack,
   output logic [NUM_CH-1:0] ch_expire,
   output logic [NUM_CH-1:0] ch_pending,
   output logic [NUM_CH-1:0] ch_active,
   output logic sched_irq
`ifdef TMR_WATCHDOG_EN
   , output logic tmr_fault
`endif
);
   sched_state_t state, state_nx;
   logic cs_nx, tick, wd_trip;
   logic [2:0] addr_nx;
   logic [15:0] data_nx;
   assign tick = state == TICK;
`ifdef TMR_WATCHDOG_EN
   logic [31:0] wd_cnt;
   assign wd_trip = state == IDLE && !tmr_irq && wd_cnt == 32'(WD_LIMIT - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
         tmr_fault <= 1'b0;
      end else begin
         wd_cnt <= (state == IDLE && !tmr_irq && !wd_trip) ? wd_cnt + 32'd1 : '0;
         if (wd_trip) tmr_fault <= 1'b1;
      end
   end
`else
   assign wd_trip = 1'b0;
`endif
   always_ff @(posedge clk) state <= reset ? INIT : state_nx;
   always_comb begin
      state_nx = state;
      cs_nx = 1'b0;
      addr_nx = TMR_ADDR_STATUS;
      data_nx = '0;
      case (state)
         INIT: begin
            cs_nx = 1'b1;
            addr_nx = TMR_ADDR_CONTROL;
            data_nx = TMR_CTRL_RUN;
            state_nx = IDLE;
         end
         IDLE: state_nx = tmr_irq ? CLEAR : wd_trip ? INIT : IDLE;
         CLEAR: begin
            cs_nx = 1'b1;
            state_nx = TICK;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_chipselect <= 1'b0;
         tmr_write_n <= 1'b1;
         tmr_address <= '0;
         tmr_writedata <= '0;
         sched_irq <= 1'b0;
      end else begin
         tmr_chipselect <= cs_nx;
         tmr_write_n <= ~cs_nx;
         tmr_address <= addr_nx;
         tmr_writedata <= data_nx;
         sched_irq <= |ch_pending;
      end
   end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_sched_channel #(.CNT_W(CNT_W)) u_ch (
         .clk(clk),
         .reset(reset),
         .tick(tick),
         .load(ch_load[i]),
         .period(ch_period[i*CNT_W +: CNT_W]),
         .oneshot(ch_oneshot[i]),
         .stop(ch_stop[i]),
         .ack(ch_ack[i]),
         .expire(ch_expire[i]),
         .pending(ch_pending[i]),
         .active(ch_active[i])
      );
   end
endmodule
